// File: rtl/maq_est_y_modos.sv
// Virtual-pet core: debounced food/medicine buttons, life-tick care FSM,
// NORMAL/TEST speed modes and a 4-digit multiplexed 7-segment display.
module maq_est_y_modos #(
    parameter int TICK_NORMAL    = 50_000_000,
    parameter int TICK_TEST      = 5_000_000,
    parameter int DEB_CYCLES     = 500_000,
    parameter int REFRESH_CYCLES = 50_000,
    parameter int MAX_LVL        = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Boton_Comida,
    input  logic       Boton_Medicina,
    output logic [6:0] sseg,
    output logic [3:0] an
);
    localparam int DW = $clog2(DEB_CYCLES);
    localparam int TW = $clog2(TICK_NORMAL);
    localparam int RW = $clog2(REFRESH_CYCLES);

    typedef enum logic [1:0] {
        FELIZ   = 2'd0,
        HAMBRE  = 2'd1,
        ENFERMO = 2'd2,
        MUERTO  = 2'd3
    } state_t;

    logic [1:0]    sync1_q, sync2_q, acc_q, prev_q;
    logic [DW-1:0] cnt_q [2];
    logic          both_q;
    logic [1:0]    press;
    logic          toggle, tick, dead;

    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          mode_q, mode_d;
    logic [3:0]    c_q, c_d, s_q, s_d;
    state_t        state_q, state_d;
    int            c_n, s_n;

    logic [RW-1:0] rcnt_q;
    logic [1:0]    sel_q;
    logic [3:0]    val;

    // bit 0 = food, bit 1 = medicine
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            acc_q    <= '0;
            prev_q   <= '0;
            both_q   <= 1'b0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            sync1_q <= {Boton_Medicina, Boton_Comida};
            sync2_q <= sync1_q;
            prev_q  <= acc_q;
            both_q  <= &acc_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == acc_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
                    acc_q[i] <= sync2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign dead   = (state_q == MUERTO);
    assign press  = acc_q & ~prev_q;
    assign toggle = (&acc_q) & ~both_q & ~dead;

    always_comb begin
        tick   = mode_q ? (tcnt_q == TW'(TICK_TEST - 1))
                        : (tcnt_q == TW'(TICK_NORMAL - 1));
        tcnt_d = (toggle || tick) ? '0 : tcnt_q + 1'b1;
        mode_d = mode_q ^ toggle;
    end

    // Same-cycle tick and press combine before saturation.
    always_comb begin
        c_n = int'(c_q) - (tick ? 1 : 0) + (press[0] ? 1 : 0);
        s_n = int'(s_q) - ((tick && c_q == 4'd0) ? 1 : 0)
                        + (press[1] ? 1 : 0);
        if (c_n < 0)       c_n = 0;
        if (c_n > MAX_LVL) c_n = MAX_LVL;
        if (s_n < 0)       s_n = 0;
        if (s_n > MAX_LVL) s_n = MAX_LVL;
        c_d = dead ? c_q : 4'(c_n);
        s_d = dead ? s_q : 4'(s_n);
    end

    always_comb begin
        state_d = FELIZ;
        if (dead || s_q == 4'd0) state_d = MUERTO;
        else if (s_q < 4'd3)     state_d = ENFERMO;
        else if (c_q < 4'd3)     state_d = HAMBRE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt_q  <= '0;
            mode_q  <= 1'b0;
            c_q     <= 4'(MAX_LVL);
            s_q     <= 4'(MAX_LVL);
            state_q <= FELIZ;
            rcnt_q  <= '0;
            sel_q   <= 2'd0;
        end else begin
            tcnt_q  <= tcnt_d;
            mode_q  <= dead ? mode_q : mode_d;
            c_q     <= c_d;
            s_q     <= s_d;
            state_q <= state_d;
            if (rcnt_q == RW'(REFRESH_CYCLES - 1)) begin
                rcnt_q <= '0;
                sel_q  <= sel_q + 2'd1;
            end else begin
                rcnt_q <= rcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        val = s_q;
        unique case (sel_q)
            2'd0: val = s_q;
            2'd1: val = c_q;
            2'd2: val = {3'b000, mode_q};
            2'd3: val = {2'b00, state_q};
        endcase
        an = ~(4'b0001 << sel_q);
    end

    always_comb begin
        sseg = 7'b1111111;
        unique case (val)
            4'h0: sseg = 7'b1000000;
            4'h1: sseg = 7'b1111001;
            4'h2: sseg = 7'b0100100;
            4'h3: sseg = 7'b0110000;
            4'h4: sseg = 7'b0011001;
            4'h5: sseg = 7'b0010010;
            4'h6: sseg = 7'b0000010;
            4'h7: sseg = 7'b1111000;
            4'h8: sseg = 7'b0000000;
            4'h9: sseg = 7'b0010000;
            4'hA: sseg = 7'b0001000;
            4'hB: sseg = 7'b0000011;
            4'hC: sseg = 7'b1000110;
            4'hD: sseg = 7'b0100001;
            4'hE: sseg = 7'b0000110;
            4'hF: sseg = 7'b0001110;
        endcase
    end
endmodule

// File: tb/tb_maq_est_y_modos.sv
// Bench for maq_est_y_modos: directed care/mode/reset scenarios plus
// randomized presses checked against an event-level pet model.
module tb_maq_est_y_modos;
    localparam int TN = 100;
    localparam int TT = 20;
    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic       clk, reset, btn_c, btn_s;
    logic [6:0] sseg;
    logic [3:0] an;
    int         cyc;
    int         checks, failures;
    int         c_m, s_m, mode_m;

    maq_est_y_modos #(
        .TICK_NORMAL(TN), .TICK_TEST(TT), .DEB_CYCLES(4),
        .REFRESH_CYCLES(8), .MAX_LVL(5)
    ) dut (
        .clk(clk), .reset(reset),
        .Boton_Comida(btn_c), .Boton_Medicina(btn_s),
        .sseg(sseg), .an(an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset)
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int pet_state(int c, int s);
        if (s == 0) return 3;
        if (s < 3)  return 2;
        if (c < 3)  return 1;
        return 0;
    endfunction

    function automatic int incr(int v);
        return (v >= 5) ? 5 : v + 1;
    endfunction

    task automatic model_reset();
        c_m = 5; s_m = 5; mode_m = 0;
    endtask

    task automatic model_tick();
        if (s_m != 0) begin
            if (c_m == 0 && s_m > 0) s_m = s_m - 1;
            if (c_m > 0) c_m = c_m - 1;
        end
    endtask

    task automatic at(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic press(input logic [1:0] v, input int len);
        @(negedge clk);
        btn_c = v[0];
        btn_s = v[1];
        repeat (len) @(negedge clk);
        btn_c = 1'b0;
        btn_s = 1'b0;
    endtask

    task automatic act(input int a);
        case (a)
            1: press(2'b01, $urandom_range(1, 2));
            2: begin
                press(2'b01, $urandom_range(6, 9));
                if (s_m != 0) c_m = incr(c_m);
            end
            3: press(2'b10, $urandom_range(1, 2));
            4: begin
                press(2'b10, $urandom_range(6, 9));
                if (s_m != 0) s_m = incr(s_m);
            end
            5: begin
                press(2'b11, 8);
                if (s_m != 0) begin
                    c_m = incr(c_m);
                    s_m = incr(s_m);
                    mode_m = 1 - mode_m;
                end
            end
            default: ;
        endcase
    endtask

    task automatic read_disp(input int e0, e1, e2, e3,
                             input logic [3:0] mask, input string tag);
        logic [6:0] g [4];
        bit         seen [4];
        int         bad, idx, ex [4];
        ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
        bad = 0;
        for (int d = 0; d < 4; d++) begin
            seen[d] = 1'b0;
            g[d] = 7'h7f;
        end
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            idx = -1;
            case (an)
                4'b1110: idx = 0;
                4'b1101: idx = 1;
                4'b1011: idx = 2;
                4'b0111: idx = 3;
                default: bad++;
            endcase
            if (idx >= 0 && mask[idx]) begin
                if (!seen[idx]) begin
                    g[idx] = sseg;
                    seen[idx] = 1'b1;
                end else if (g[idx] !== sseg) begin
                    bad++;
                end
            end
        end
        checks++;
        assert (bad === 0) else begin
            failures++;
            $error("FAIL %s scan: bad samples=%0d expected 0", tag, bad);
        end
        for (int d = 0; d < 4; d++) begin
            if (mask[d]) begin
                checks++;
                assert (seen[d] && g[d] === GLYPH[ex[d]]) else begin
                    failures++;
                    $error("FAIL %s digit%0d: got %b expected %b",
                           tag, d, g[d], GLYPH[ex[d]]);
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        read_disp(s_m, c_m, mode_m, pet_state(c_m, s_m), 4'hF, tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        assert (an === 4'b1110) else begin
            failures++;
            $error("FAIL %s an: got %b expected 1110", tag, an);
        end
        checks++;
        assert (sseg === GLYPH[5]) else begin
            failures++;
            $error("FAIL %s sseg: got %b expected %b", tag, sseg, GLYPH[5]);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        btn_c = 1'b0;
        btn_s = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic period(input int k, input int a1, a2, input string tag);
        at(k * TN);
        if (k > 0) model_tick();
        at(k * TN + 3);
        act(a1);
        at(k * TN + 22);
        act(a2);
        at(k * TN + 45);
        check_model(tag);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        btn_c = 1'b0;
        btn_s = 1'b0;
        reset = 1'b1;
        #23;
        reset_dut();

        // countdown, short/long presses, saturation, death
        period(0, 0, 0, "p0_full");
        period(1, 0, 0, "p1");
        period(2, 1, 0, "p2_short");
        period(3, 0, 0, "p3_hambre");
        period(4, 2, 2, "p4_feed");
        period(5, 2, 2, "p5_feed");
        period(6, 2, 2, "p6_feed");
        period(7, 2, 2, "p7_sat");
        for (int k = 8; k < 18; k++) period(k, 0, 0, "decay");
        period(18, 5, 2, "dead_press");
        period(19, 4, 0, "dead_hold");

        // TEST mode entry/exit, then asynchronous reset mid-countdown
        reset_dut();
        at(10);
        act(5);
        at(60);
        read_disp(0, 0, 1, 0, 4'b0100, "test_mode");
        repeat (6) model_tick();
        at(140);
        act(5);
        at(160);
        check_model("back_normal");
        at(200);
        act(5);
        at(240);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        at(20);
        check_model("after_reset");

        // randomized care sessions in NORMAL mode
        reset_dut();
        for (int k = 0; k < 30; k++)
            period(k, $urandom_range(0, 4), $urandom_range(0, 4), "rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
